// File: rtl/best_arr_sender.sv
// Streams the best-match index array to an output FIFO in block-interleaved order,
// reading a 1-cycle-latency memory through a 2-entry skid buffer.
module best_arr_sender #(
  parameter int unsigned DATA_WIDTH = 11,
  parameter int unsigned IDX_WIDTH  = 9,
  parameter int unsigned ROW_SIZE   = 26,
  parameter int unsigned COL_SIZE   = 19,
  parameter int unsigned BLOCKING   = 4,
  parameter int unsigned NUM_QUERYS = ROW_SIZE * COL_SIZE,
  parameter int unsigned AW         = $clog2(NUM_QUERYS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  send_best_arr,
  output logic                  busy,
  output logic                  send_done,
  output logic                  rd_en,
  output logic [AW-1:0]         rd_addr,
  input  logic [IDX_WIDTH-1:0]  rd_data,
  output logic                  out_fifo_wenq,
  output logic [DATA_WIDTH-1:0] out_fifo_wdata,
  input  logic                  out_fifo_wfull_n
);

  localparam int unsigned HALF    = ROW_SIZE / 2;
  localparam int unsigned XBLKS   = (HALF + BLOCKING - 1) / BLOCKING;
  localparam int unsigned LAST_XI = HALF - (XBLKS - 1) * BLOCKING;
  localparam int unsigned XW      = (XBLKS > 1) ? $clog2(XBLKS) : 1;
  localparam int unsigned YW      = (COL_SIZE > 1) ? $clog2(COL_SIZE) : 1;
  localparam int unsigned IW      = (BLOCKING > 1) ? $clog2(BLOCKING) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e               state_q, state_d;
  logic                 px_q, px_d;
  logic [XW-1:0]        x_q, x_d;
  logic [YW-1:0]        y_q, y_d;
  logic [IW-1:0]        xi_q, xi_d;
  logic                 inflight_q, inflight_d;
  logic [1:0]           cnt_q, cnt_d;
  logic [IDX_WIDTH-1:0] buf_q [2];
  logic [IDX_WIDTH-1:0] buf_d [2];
  logic                 done_q, done_d;

  logic       wenq;
  logic [2:0] occ;
  logic       room;
  logic       x_last, y_last, xi_last, last_rd, issue;
  logic [1:0] cnt_pop;

  assign wenq    = (cnt_q != 2'd0) && out_fifo_wfull_n;
  // Occupancy counts words already buffered plus the read whose data lands next edge.
  assign occ     = {1'b0, cnt_q} + {2'b0, inflight_q};
  assign room    = occ < (3'd2 + {2'b0, wenq});
  assign x_last  = x_q == XW'(XBLKS - 1);
  assign y_last  = y_q == YW'(COL_SIZE - 1);
  assign xi_last = x_last ? (xi_q == IW'(LAST_XI - 1)) : (xi_q == IW'(BLOCKING - 1));
  assign last_rd = px_q && x_last && y_last && xi_last;
  assign issue   = (state_q == StRun) && room;
  assign cnt_pop = cnt_q - {1'b0, wenq};

  assign busy           = state_q != StIdle;
  assign send_done      = done_q;
  assign rd_en          = issue;
  assign rd_addr        = AW'(32'(px_q) * HALF + 32'(y_q) * ROW_SIZE +
                              32'(x_q) * BLOCKING + 32'(xi_q));
  assign out_fifo_wenq  = wenq;
  assign out_fifo_wdata = DATA_WIDTH'(buf_q[0]);

  always_comb begin
    state_d    = state_q;
    px_d       = px_q;
    x_d        = x_q;
    y_d        = y_q;
    xi_d       = xi_q;
    done_d     = 1'b0;
    inflight_d = issue;
    cnt_d      = cnt_q + {1'b0, inflight_q} - {1'b0, wenq};
    buf_d      = buf_q;

    if (wenq) begin
      buf_d[0] = buf_q[1];
    end
    if (inflight_q) begin
      if (cnt_pop == 2'd0) buf_d[0] = rd_data;
      else                 buf_d[1] = rd_data;
    end

    // Innermost xi, then y, then x, then px; wraps to all-zero after the last read.
    if (issue) begin
      if (!xi_last) begin
        xi_d = xi_q + 1'b1;
      end else begin
        xi_d = '0;
        if (!y_last) begin
          y_d = y_q + 1'b1;
        end else begin
          y_d = '0;
          if (!x_last) begin
            x_d = x_q + 1'b1;
          end else begin
            x_d  = '0;
            px_d = ~px_q;
          end
        end
      end
    end

    unique case (state_q)
      StIdle: begin
        if (send_best_arr) begin
          state_d = StRun;
          px_d    = 1'b0;
          x_d     = '0;
          y_d     = '0;
          xi_d    = '0;
        end
      end
      StRun: begin
        if (issue && last_rd) state_d = StDrain;
      end
      StDrain: begin
        if (wenq && (cnt_q == 2'd1) && !inflight_q) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      px_q       <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      xi_q       <= '0;
      inflight_q <= 1'b0;
      cnt_q      <= 2'd0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      px_q       <= px_d;
      x_q        <= x_d;
      y_q        <= y_d;
      xi_q       <= xi_d;
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
      buf_q      <= buf_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_best_arr_sender.sv
// Bench for best_arr_sender: default geometry (26x19) and a 16x19 geometry instance,
// each fed by a modelled 1-cycle-latency memory.
module tb_best_arr_sender;

  localparam int NQ_A = 26 * 19;
  localparam int NQ_B = 16 * 19;
  localparam int AWA  = $clog2(NQ_A);
  localparam int AWB  = $clog2(NQ_B);

  logic clk;
  logic rst_n;

  logic            a_send, a_busy, a_done, a_rd_en, a_wenq, a_wfull_n;
  logic [AWA-1:0]  a_rd_addr;
  logic [8:0]      a_rd_data;
  logic [10:0]     a_wdata;
  logic            b_send, b_busy, b_done, b_rd_en, b_wenq, b_wfull_n;
  logic [AWB-1:0]  b_rd_addr;
  logic [8:0]      b_rd_data;
  logic [10:0]     b_wdata;

  logic [8:0] mem_a [NQ_A];
  logic [8:0] mem_b [NQ_B];
  int exp_q[$];
  int vectors;
  int miscompares;

  best_arr_sender u_dut_a (
    .clk              (clk),
    .rst_n            (rst_n),
    .send_best_arr    (a_send),
    .busy             (a_busy),
    .send_done        (a_done),
    .rd_en            (a_rd_en),
    .rd_addr          (a_rd_addr),
    .rd_data          (a_rd_data),
    .out_fifo_wenq    (a_wenq),
    .out_fifo_wdata   (a_wdata),
    .out_fifo_wfull_n (a_wfull_n)
  );

  best_arr_sender #(
    .ROW_SIZE (16)
  ) u_dut_b (
    .clk              (clk),
    .rst_n            (rst_n),
    .send_best_arr    (b_send),
    .busy             (b_busy),
    .send_done        (b_done),
    .rd_en            (b_rd_en),
    .rd_addr          (b_rd_addr),
    .rd_data          (b_rd_data),
    .out_fifo_wenq    (b_wenq),
    .out_fifo_wdata   (b_wdata),
    .out_fifo_wfull_n (b_wfull_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (a_rd_en) a_rd_data <= mem_a[a_rd_addr];
    if (b_rd_en) b_rd_data <= mem_b[b_rd_addr];
  end

  // Reference visiting order built straight from the nested-counter rules.
  task automatic build_exp(input int row, input int col, input int blk);
    int half, xb, lx;
    half = row / 2;
    xb   = (half + blk - 1) / blk;
    lx   = half - (xb - 1) * blk;
    exp_q.delete();
    for (int px = 0; px < 2; px++)
      for (int x = 0; x < xb; x++)
        for (int y = 0; y < col; y++)
          for (int xi = 0; xi < blk; xi++)
            if (!(x == xb - 1 && xi >= lx)) exp_q.push_back(px * half + y * row + x * blk + xi);
  endtask

  task automatic fill_mems();
    foreach (mem_a[i]) mem_a[i] = 9'($urandom);
    foreach (mem_b[i]) mem_b[i] = 9'($urandom);
  endtask

  task automatic start_a();
    @(negedge clk);
    a_send = 1'b1;
    @(negedge clk);
    a_send = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if ({a_busy, a_done, a_rd_en, a_wenq} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_ctl_a: got %b want 0000", {a_busy, a_done, a_rd_en, a_wenq});
    end
    vectors++;
    if (a_rd_addr !== '0 || a_wdata !== '0) begin
      miscompares++;
      $display("FAIL reset_data_a: got addr %0d wdata %0d want 0 0", a_rd_addr, a_wdata);
    end
    vectors++;
    if ({b_busy, b_done, b_rd_en, b_wenq} !== 4'b0 || b_rd_addr !== '0 || b_wdata !== '0) begin
      miscompares++;
      $display("FAIL reset_b: got ctl %b addr %0d wdata %0d want all 0",
               {b_busy, b_done, b_rd_en, b_wenq}, b_rd_addr, b_wdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_stream();
    int k, nr, bad;
    int seen[NQ_A];
    bit exp_wenq, exp_done, exp_busy;
    fill_mems();
    build_exp(26, 19, 4);
    foreach (seen[i]) seen[i] = 0;
    a_wfull_n = 1'b1;
    k = 0;
    nr = 0;
    start_a();
    #1;
    vectors++;
    if (a_rd_en !== 1'b1 || a_rd_addr !== '0) begin
      miscompares++;
      $display("FAIL first_read: got en %b addr %0d want 1 0", a_rd_en, a_rd_addr);
    end
    for (int c = 1; c <= 500; c++) begin
      if (c > 1) begin
        @(negedge clk);
        #1;
      end
      if (a_rd_en === 1'b1) begin
        vectors++;
        if (nr >= exp_q.size() || int'(a_rd_addr) != exp_q[nr]) begin
          miscompares++;
          $display("FAIL rd_addr[%0d]: got %0d want %0d", nr, a_rd_addr,
                   (nr < exp_q.size()) ? exp_q[nr] : -1);
        end
        if (int'(a_rd_addr) < NQ_A) seen[a_rd_addr]++;
        nr++;
      end
      exp_wenq = (c >= 3 && c <= 496);
      exp_done = (c == 497);
      exp_busy = (c <= 496);
      vectors++;
      if (a_wenq !== exp_wenq) begin
        miscompares++;
        $display("FAIL wenq_cycle %0d: got %b want %b", c, a_wenq, exp_wenq);
      end
      if (a_wenq === 1'b1 && k < exp_q.size()) begin
        vectors++;
        if (a_wdata !== {2'b0, mem_a[exp_q[k]]}) begin
          miscompares++;
          $display("FAIL word[%0d]: got %0d want %0d", k, a_wdata, mem_a[exp_q[k]]);
        end
        k++;
      end
      vectors++;
      if (a_done !== exp_done || a_busy !== exp_busy) begin
        miscompares++;
        $display("FAIL done_busy cycle %0d: got %b%b want %b%b", c, a_done, a_busy,
                 exp_done, exp_busy);
      end
    end
    bad = 0;
    foreach (seen[i]) if (seen[i] != 1) bad++;
    vectors++;
    if (nr != NQ_A || bad != 0) begin
      miscompares++;
      $display("FAIL read_cover: got %0d reads %0d bad addrs want %0d 0", nr, bad, NQ_A);
    end
  endtask

  task automatic test_random_full();
    int k, dones, c;
    fill_mems();
    build_exp(26, 19, 4);
    k = 0;
    dones = 0;
    c = 0;
    start_a();
    while (dones == 0 && c < 4000) begin
      a_wfull_n = 1'($urandom_range(0, 1));
      #1;
      vectors++;
      if (a_wenq === 1'b1 && a_wfull_n == 1'b0) begin
        miscompares++;
        $display("FAIL wenq_while_full: got 1 want 0 at cycle %0d", c);
      end
      if (a_wenq === 1'b1) begin
        vectors++;
        if (k >= exp_q.size() || a_wdata !== {2'b0, mem_a[exp_q[k]]}) begin
          miscompares++;
          $display("FAIL rand_word[%0d]: got %0d want %0d", k, a_wdata,
                   (k < exp_q.size()) ? int'(mem_a[exp_q[k]]) : -1);
        end
        k++;
      end
      if (a_done === 1'b1) dones++;
      @(negedge clk);
      c++;
    end
    a_wfull_n = 1'b1;
    vectors++;
    if (k != NQ_A || dones != 1) begin
      miscompares++;
      $display("FAIL rand_total: got %0d words %0d dones want %0d 1", k, dones, NQ_A);
    end
  endtask

  task automatic test_stall();
    int k, reads, dones, c;
    fill_mems();
    build_exp(26, 19, 4);
    k = 0;
    reads = 0;
    dones = 0;
    a_wfull_n = 1'b0;
    start_a();
    for (int i = 0; i < 20; i++) begin
      #1;
      if (a_rd_en === 1'b1) reads++;
      vectors++;
      if (a_wenq !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_wenq: got %b want 0", a_wenq);
      end
      @(negedge clk);
    end
    vectors++;
    if (reads > 2 || reads == 0) begin
      miscompares++;
      $display("FAIL stall_reads: got %0d want 1..2", reads);
    end
    a_wfull_n = 1'b1;
    c = 0;
    while (dones == 0 && c < 1000) begin
      #1;
      if (a_wenq === 1'b1) begin
        vectors++;
        if (k >= exp_q.size() || a_wdata !== {2'b0, mem_a[exp_q[k]]}) begin
          miscompares++;
          $display("FAIL stall_word[%0d]: got %0d want %0d", k, a_wdata,
                   (k < exp_q.size()) ? int'(mem_a[exp_q[k]]) : -1);
        end
        k++;
      end
      if (a_done === 1'b1) dones++;
      @(negedge clk);
      c++;
    end
    vectors++;
    if (k != NQ_A || dones != 1) begin
      miscompares++;
      $display("FAIL stall_total: got %0d words %0d dones want %0d 1", k, dones, NQ_A);
    end
  endtask

  task automatic test_restart_ignored();
    int k, dones, c;
    fill_mems();
    build_exp(26, 19, 4);
    k = 0;
    dones = 0;
    c = 0;
    a_wfull_n = 1'b1;
    start_a();
    while (c < 560) begin
      #1;
      if (a_wenq === 1'b1) begin
        vectors++;
        if (k >= exp_q.size() || a_wdata !== {2'b0, mem_a[exp_q[k]]}) begin
          miscompares++;
          $display("FAIL restart_word[%0d]: got %0d want %0d", k, a_wdata,
                   (k < exp_q.size()) ? int'(mem_a[exp_q[k]]) : -1);
        end
        k++;
      end
      if (a_done === 1'b1) dones++;
      if (dones > 0 && a_done !== 1'b1) begin
        vectors++;
        if (a_busy !== 1'b0 || a_wenq !== 1'b0) begin
          miscompares++;
          $display("FAIL restart_idle: got busy %b wenq %b want 0 0", a_busy, a_wenq);
        end
      end
      @(negedge clk);
      a_send = (a_busy === 1'b1) && ((c % 7) == 3);
      c++;
    end
    a_send = 1'b0;
    vectors++;
    if (k != NQ_A || dones != 1) begin
      miscompares++;
      $display("FAIL restart_total: got %0d words %0d dones want %0d 1", k, dones, NQ_A);
    end
  endtask

  task automatic test_reset_mid();
    int k, c;
    fill_mems();
    build_exp(26, 19, 4);
    k = 0;
    c = 0;
    a_wfull_n = 1'b1;
    start_a();
    while (k <= 100 && c < 1000) begin
      #1;
      if (a_wenq === 1'b1) begin
        vectors++;
        if (a_wdata !== {2'b0, mem_a[exp_q[k]]}) begin
          miscompares++;
          $display("FAIL pre_reset_word[%0d]: got %0d want %0d", k, a_wdata, mem_a[exp_q[k]]);
        end
        if (k == 100) rst_n = 1'b0;
        k++;
      end
      @(negedge clk);
      c++;
    end
    #1;
    vectors++;
    if ({a_busy, a_done, a_rd_en, a_wenq} !== 4'b0 || a_rd_addr !== '0 || a_wdata !== '0) begin
      miscompares++;
      $display("FAIL mid_reset: got ctl %b addr %0d wdata %0d want all 0",
               {a_busy, a_done, a_rd_en, a_wenq}, a_rd_addr, a_wdata);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      vectors++;
      if (a_wenq !== 1'b0 || a_busy !== 1'b0) begin
        miscompares++;
        $display("FAIL stale_after_reset: got wenq %b busy %b want 0 0", a_wenq, a_busy);
      end
    end
  endtask

  task automatic test_alt_geometry();
    int k, nr, dones, c, bad;
    int seen[NQ_B];
    fill_mems();
    build_exp(16, 19, 4);
    foreach (seen[i]) seen[i] = 0;
    k = 0;
    nr = 0;
    dones = 0;
    c = 0;
    b_wfull_n = 1'b1;
    @(negedge clk);
    b_send = 1'b1;
    @(negedge clk);
    b_send = 1'b0;
    while (dones == 0 && c < 3000) begin
      b_wfull_n = ($urandom_range(0, 3) != 0);
      #1;
      if (b_rd_en === 1'b1) begin
        if (int'(b_rd_addr) < NQ_B) seen[b_rd_addr]++;
        nr++;
      end
      if (b_wenq === 1'b1) begin
        vectors++;
        if (k >= exp_q.size() || b_wdata !== {2'b0, mem_b[exp_q[k]]}) begin
          miscompares++;
          $display("FAIL alt_word[%0d]: got %0d want %0d", k, b_wdata,
                   (k < exp_q.size()) ? int'(mem_b[exp_q[k]]) : -1);
        end
        k++;
      end
      if (b_done === 1'b1) dones++;
      @(negedge clk);
      c++;
    end
    b_wfull_n = 1'b1;
    bad = 0;
    foreach (seen[i]) if (seen[i] != 1) bad++;
    vectors++;
    if (k != NQ_B || dones != 1 || nr != NQ_B || bad != 0) begin
      miscompares++;
      $display("FAIL alt_total: got %0d words %0d dones %0d reads %0d bad want %0d 1 %0d 0",
               k, dones, nr, bad, NQ_B, NQ_B);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    a_send      = 1'b0;
    b_send      = 1'b0;
    a_wfull_n   = 1'b1;
    b_wfull_n   = 1'b1;
    fill_mems();
    test_reset();
    test_stream();
    test_random_full();
    test_stall();
    test_restart_ignored();
    test_reset_mid();
    test_stream();
    test_alt_geometry();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
